// File: rtl/dm_arbiter.sv
// Data-memory port arbiter: the CPU execute stage has default priority, and one external
// requester gets bounded-wait, burst-capable access. The CPU is stalled whenever it loses the port.
module dm_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 16,
    parameter int MAX_BURST    = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_en,
    input  logic              cpu_rw,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_stall,
    input  logic              ext_req,
    input  logic              ext_rw,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    output logic              ext_gnt,
    output logic              ext_rvalid,
    output logic [DATA_W-1:0] ext_rdata,
    output logic              mem_en,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              owner
);

    localparam logic [0:0] S_CPU = 1'b0;
    localparam logic [0:0] S_EXT = 1'b1;

    localparam int WAIT_W  = $clog2(STARVE_LIMIT + 1);
    localparam int BURST_W = $clog2(MAX_BURST + 1);
    localparam logic [WAIT_W-1:0]  WAIT_MAX  = WAIT_W'(STARVE_LIMIT);
    localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_BURST);

    logic [0:0]         state_reg, state_next;
    logic [WAIT_W-1:0]  wait_cnt_reg, wait_cnt_next;
    logic [BURST_W-1:0] burst_cnt_reg, burst_cnt_next;
    logic               ext_rvalid_reg;
    logic               cpu_sel;
    logic               ext_sel;

    always_comb begin
        state_next     = state_reg;
        wait_cnt_next  = wait_cnt_reg;
        burst_cnt_next = burst_cnt_reg;
        cpu_sel        = 1'b0;
        ext_sel        = 1'b0;
        case (state_reg)
            S_CPU: begin
                if (ext_req && (!cpu_en || wait_cnt_reg == WAIT_MAX)) begin
                    ext_sel        = 1'b1;
                    state_next     = S_EXT;
                    burst_cnt_next = BURST_W'(1);
                    wait_cnt_next  = '0;
                end else if (cpu_en) begin
                    cpu_sel = 1'b1;
                    // Only reached with wait_cnt below the limit when ext_req is high, so this saturates.
                    wait_cnt_next = ext_req ? wait_cnt_reg + WAIT_W'(1) : '0;
                end else begin
                    wait_cnt_next = '0;
                end
            end
            default: begin
                if (ext_req && burst_cnt_reg < BURST_MAX) begin
                    ext_sel        = 1'b1;
                    burst_cnt_next = burst_cnt_reg + BURST_W'(1);
                end else begin
                    cpu_sel        = cpu_en;
                    state_next     = S_CPU;
                    burst_cnt_next = '0;
                    wait_cnt_next  = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= S_CPU;
            wait_cnt_reg   <= '0;
            burst_cnt_reg  <= '0;
            ext_rvalid_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            wait_cnt_reg   <= wait_cnt_next;
            burst_cnt_reg  <= burst_cnt_next;
            ext_rvalid_reg <= ext_gnt & ~ext_rw;
        end
    end

    // Grants are masked while reset is low; the mux then falls back to the CPU side.
    assign ext_gnt    = ext_sel & reset;
    assign mem_en     = (ext_sel | cpu_sel) & reset;
    assign cpu_stall  = cpu_en & ext_gnt;
    assign mem_rw     = ext_gnt ? ext_rw    : cpu_rw;
    assign mem_addr   = ext_gnt ? ext_addr  : cpu_addr;
    assign mem_wdata  = ext_gnt ? ext_wdata : cpu_wdata;
    assign ext_rvalid = ext_rvalid_reg;
    assign ext_rdata  = ext_rvalid_reg ? mem_rdata : '0;
    assign owner      = state_reg;

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with a small synchronous-read memory model on the mem_* port.
module tb_dm_arbiter;

    logic        clk;
    logic        reset;
    logic        cpu_en, cpu_rw;
    logic [15:0] cpu_addr, cpu_wdata;
    logic        cpu_stall;
    logic        ext_req, ext_rw;
    logic [15:0] ext_addr, ext_wdata;
    logic        ext_gnt, ext_rvalid;
    logic [15:0] ext_rdata;
    logic        mem_en, mem_rw;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        owner;

    logic        init_mem;
    logic [15:0] mem [0:1023];

    int n_cmp = 0;
    int n_err = 0;

    dm_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_en    (cpu_en),
        .cpu_rw    (cpu_rw),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_stall (cpu_stall),
        .ext_req   (ext_req),
        .ext_rw    (ext_rw),
        .ext_addr  (ext_addr),
        .ext_wdata (ext_wdata),
        .ext_gnt   (ext_gnt),
        .ext_rvalid(ext_rvalid),
        .ext_rdata (ext_rdata),
        .mem_en    (mem_en),
        .mem_rw    (mem_rw),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .owner     (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Preload pattern: word at address a holds 0xC000 ^ a.
    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 16'hC000 ^ 16'(i);
        end else if (mem_en) begin
            if (mem_rw) mem[mem_addr[9:0]] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr[9:0]];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%04h expected=%04h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0]  g3, o3;
        logic [8:0]  g4, o4;
        logic [5:0]  g5;
        logic [3:0]  g6;
        logic [15:0] k;
        logic        prev_g;
        logic [15:0] prev_a;

        mem_rdata = 16'h0000;
        cpu_rw = 1'b0; cpu_addr = 16'h0040; cpu_wdata = 16'h0000;
        ext_rw = 1'b0; ext_addr = 16'h0000; ext_wdata = 16'h0000;

        // Test 1: reset low with both sides requesting
        reset = 1'b0; cpu_en = 1'b1; ext_req = 1'b1; init_mem = 1'b1;
        #2;
        chk1("t1_rst_mem_en", mem_en, 1'b0);
        chk1("t1_rst_ext_gnt", ext_gnt, 1'b0);
        chk1("t1_rst_stall", cpu_stall, 1'b0);
        chk1("t1_rst_owner", owner, 1'b0);
        tick(); init_mem = 1'b0; #1;
        chk1("t1_rst2_mem_en", mem_en, 1'b0);
        chk1("t1_rst2_ext_gnt", ext_gnt, 1'b0);
        tick(); reset = 1'b1; #1;
        chk1("t1_rel_mem_en", mem_en, 1'b1);
        chk1("t1_rel_ext_gnt", ext_gnt, 1'b0);
        chk1("t1_rel_stall", cpu_stall, 1'b0);
        chk16("t1_rel_addr", mem_addr, 16'h0040);
        tick(); cpu_en = 1'b0; ext_req = 1'b0; #1;
        $display("t1 reset/release done");

        // Test 2: CPU-only read then write
        tick(); cpu_en = 1'b1; cpu_rw = 1'b0; cpu_addr = 16'h0010; #1;
        chk1("t2_rd_en", mem_en, 1'b1);
        chk1("t2_rd_rw", mem_rw, 1'b0);
        chk16("t2_rd_addr", mem_addr, 16'h0010);
        chk1("t2_rd_stall", cpu_stall, 1'b0);
        chk1("t2_rd_gnt", ext_gnt, 1'b0);
        tick(); cpu_rw = 1'b1; cpu_addr = 16'h0011; cpu_wdata = 16'h00AB; #1;
        chk1("t2_wr_en", mem_en, 1'b1);
        chk1("t2_wr_rw", mem_rw, 1'b1);
        chk16("t2_wr_addr", mem_addr, 16'h0011);
        chk16("t2_wr_data", mem_wdata, 16'h00AB);
        chk1("t2_wr_gnt", ext_gnt, 1'b0);
        chk1("t2_no_rvalid", ext_rvalid, 1'b0);
        tick(); cpu_en = 1'b0; cpu_rw = 1'b0; #1;
        chk16("t2_mem_written", mem[16'h0011], 16'h00AB);
        $display("t2 cpu read/write done");

        // Test 3: idle CPU, six external reads; S_EXT exit cycle grants nobody, then S_CPU re-grants
        g3 = 8'b0110_1111;
        o3 = 8'b1101_1110;
        k = 16'h0000; prev_g = 1'b0; prev_a = 16'h0000;
        for (int c = 0; c < 8; c++) begin
            tick();
            cpu_en = 1'b0; ext_req = (k < 16'd6); ext_rw = 1'b0; ext_addr = 16'h0100 + k;
            #1;
            chk1("t3_gnt", ext_gnt, g3[c]);
            chk1("t3_owner", owner, o3[c]);
            chk1("t3_rvalid", ext_rvalid, prev_g);
            if (prev_g) chk16("t3_rdata", ext_rdata, 16'hC000 ^ prev_a);
            else        chk16("t3_rdata_gated", ext_rdata, 16'h0000);
            if (g3[c])  chk16("t3_addr", mem_addr, 16'h0100 + k);
            $display("t3 cycle %0d gnt=%0b rvalid=%0b rdata=%04h", c, ext_gnt, ext_rvalid, ext_rdata);
            prev_g = g3[c];
            prev_a = 16'h0100 + k;
            if (g3[c]) k = k + 16'd1;
        end
        tick(); ext_req = 1'b0; #1;
        chk1("t3_owner_back", owner, 1'b0);
        chk1("t3_rvalid_end", ext_rvalid, 1'b0);

        // Test 4: busy CPU, external writes force-granted after three waits, burst of four
        g4 = 9'b001111000;
        o4 = 9'b011110000;
        k = 16'h0000;
        for (int c = 0; c < 9; c++) begin
            tick();
            cpu_en = 1'b1; cpu_rw = 1'b0; cpu_addr = 16'h0200;
            ext_req = 1'b1; ext_rw = 1'b1; ext_addr = 16'h0300 + k; ext_wdata = 16'hE000 + k;
            #1;
            chk1("t4_gnt", ext_gnt, g4[c]);
            chk1("t4_stall", cpu_stall, g4[c]);
            chk1("t4_owner", owner, o4[c]);
            chk1("t4_mem_en", mem_en, 1'b1);
            chk16("t4_addr", mem_addr, g4[c] ? 16'h0300 + k : 16'h0200);
            chk1("t4_rvalid", ext_rvalid, 1'b0);
            $display("t4 cycle %0d gnt=%0b stall=%0b owner=%0b addr=%04h", c, ext_gnt, cpu_stall, owner, mem_addr);
            if (g4[c]) k = k + 16'd1;
        end
        tick(); cpu_en = 1'b0; ext_req = 1'b0; #1;
        chk16("t4_wr0", mem[16'h0300], 16'hE000);
        chk16("t4_wr1", mem[16'h0301], 16'hE001);
        chk16("t4_wr2", mem[16'h0302], 16'hE002);
        chk16("t4_wr3", mem[16'h0303], 16'hE003);
        chk16("t4_unwritten", mem[16'h0304], 16'hC304);

        // Test 5: as test 4 but ext_req drops after the second external grant
        g5 = 6'b011000;
        k = 16'h0000;
        for (int c = 0; c < 6; c++) begin
            tick();
            cpu_en = 1'b1; cpu_rw = 1'b1; cpu_addr = 16'h0222; cpu_wdata = 16'h5A5A;
            ext_req = (c < 5); ext_rw = 1'b1; ext_addr = 16'h0310 + k; ext_wdata = 16'hD000 + k;
            #1;
            chk1("t5_gnt", ext_gnt, g5[c]);
            chk1("t5_stall", cpu_stall, g5[c]);
            chk16("t5_addr", mem_addr, g5[c] ? 16'h0310 + k : 16'h0222);
            $display("t5 cycle %0d gnt=%0b stall=%0b addr=%04h", c, ext_gnt, cpu_stall, mem_addr);
            if (g5[c]) k = k + 16'd1;
        end
        chk16("t5_cpu_wdata", mem_wdata, 16'h5A5A);
        chk1("t5_owner_still_ext", owner, 1'b1);
        tick(); cpu_en = 1'b0; ext_req = 1'b0; #1;
        chk1("t5_owner_back", owner, 1'b0);
        chk16("t5_cpu_mem", mem[16'h0222], 16'h5A5A);
        chk16("t5_ext_mem0", mem[16'h0310], 16'hD000);
        chk16("t5_ext_mem1", mem[16'h0311], 16'hD001);

        // Test 6: reset during an external read grant with burst_cnt=2
        tick(); cpu_en = 1'b0; ext_req = 1'b1; ext_rw = 1'b0; ext_addr = 16'h0100; #1;
        chk1("t6_gnt0", ext_gnt, 1'b1);
        tick(); ext_addr = 16'h0101; #1;
        chk1("t6_gnt1", ext_gnt, 1'b1);
        chk1("t6_rvalid1", ext_rvalid, 1'b1);
        chk16("t6_rdata1", ext_rdata, 16'hC100);
        tick(); ext_addr = 16'h0102; #1;
        chk1("t6_gnt2", ext_gnt, 1'b1);
        chk1("t6_owner2", owner, 1'b1);
        reset = 1'b0; #1;
        chk1("t6_rst_owner", owner, 1'b0);
        chk1("t6_rst_gnt", ext_gnt, 1'b0);
        chk1("t6_rst_mem_en", mem_en, 1'b0);
        chk1("t6_rst_rvalid", ext_rvalid, 1'b0);
        tick(); #1;
        chk1("t6_rst_rvalid_after_edge", ext_rvalid, 1'b0);
        chk16("t6_rst_rdata", ext_rdata, 16'h0000);
        g6 = 4'b1000;
        for (int c = 0; c < 4; c++) begin
            tick();
            reset = 1'b1; cpu_en = 1'b1; cpu_rw = 1'b0; cpu_addr = 16'h0050; ext_req = 1'b1;
            #1;
            chk1("t6_rel_gnt", ext_gnt, g6[c]);
            chk1("t6_rel_stall", cpu_stall, g6[c]);
            chk1("t6_rel_rvalid", ext_rvalid, 1'b0);
            $display("t6 cycle %0d gnt=%0b stall=%0b", c, ext_gnt, cpu_stall);
        end
        tick(); cpu_en = 1'b0; ext_req = 1'b0; #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
